dds_phase_accumulator: RTL and testbench

//  Phase-accumulator (NCO) front end of the DDS chain. Drives the 11-bit address of the sine lookup stage.

---
 rtl/dds_phase_accumulator.sv | 205 ++++++++++++++++++++
 tb/tb_dds_phase_accumulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_accumulator.sv
// Phase accumulator (NCO) front end for the DDS sine lookup, with linear FTW sweep.
// Optional phase dither: define PHASE_DITHER_EN to add LFSR noise below the address LSB.
module dds_phase_accumulator #(
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = 11,
   parameter int LUT_LAT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              halt,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic              cfg_sweep,
   input  logic              cfg_clr,
   input  logic [ACC_W-1:0]  cfg_ftw,
   input  logic [ACC_W-1:0]  cfg_step,
   input  logic [ACC_W-1:0]  cfg_stop,
   input  logic [ADDR_W-1:0] cfg_phase,
   output logic [ADDR_W-1:0] phase_addr,
   output logic              addr_valid,
   output logic              lut_valid,
   output logic              wrap,
   output logic              sweep_done,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_SWEEP
   } state_e;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    ftw_q, ftw_d;
   logic [ACC_W-1:0]    step_q, step_d;
   logic [ACC_W-1:0]    stop_q, stop_d;
   logic [ADDR_W-1:0]   offset_q, offset_d;
   logic [ADDR_W-1:0]   phase_addr_q, phase_addr_d;
   logic                addr_valid_q, addr_valid_d;
   logic                wrap_q, wrap_d;
   logic                sweep_done_q, sweep_done_d;
   logic [LUT_LAT-1:0]  lut_q, lut_d;

   logic                accept;
   logic                active;
   logic [ACC_W:0]      acc_sum;
   logic [ACC_W:0]      swp_nxt;
   logic                swp_hit;
   logic [ADDR_W-1:0]   acc_top;

   assign active    = (state_q != ST_IDLE);
   assign cfg_ready = (state_q != ST_SWEEP) && !halt;
   assign accept    = cfg_valid && cfg_ready;

   // Wide adds keep the carry for wrap and the sweep overshoot compare.
   assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
   assign swp_nxt = {1'b0, ftw_q} + {1'b0, step_q};
   assign swp_hit = (swp_nxt >= {1'b0, stop_q});

`ifdef PHASE_DITHER_EN
   localparam int DW = ((ACC_W - ADDR_W) > 16) ? 16 : (ACC_W - ADDR_W);

   logic [15:0]      lfsr_q, lfsr_d;
   logic             lfsr_fb;
   logic [ACC_W-1:0] acc_dith;

   assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign acc_dith = acc_q + ACC_W'(lfsr_q[DW-1:0]);
   assign acc_top  = acc_dith[ACC_W-1 -: ADDR_W];

   // Dither LFSR advances only on enabled cycles.
   always_comb begin
      lfsr_d = lfsr_q;
      if (enable) begin
         lfsr_d = {lfsr_fb, lfsr_q[15:1]};
      end
   end

   // Dither LFSR register, seeded on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign acc_top = acc_q[ACC_W-1 -: ADDR_W];
`endif

   // Next state, accumulator, FTW sweep and config capture.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      ftw_d        = ftw_q;
      step_d       = step_q;
      stop_d       = stop_q;
      offset_d     = offset_q;
      wrap_d       = 1'b0;
      sweep_done_d = 1'b0;
      if (halt) begin
         state_d = ST_IDLE;
         acc_d   = '0;
      end else begin
         if (enable && active) begin
            acc_d  = acc_sum[ACC_W-1:0];
            wrap_d = acc_sum[ACC_W];
         end
         unique case (state_q)
            ST_SWEEP: begin
               if (enable) begin
                  if (swp_hit) begin
                     ftw_d        = stop_q;
                     sweep_done_d = 1'b1;
                     state_d      = ST_RUN;
                  end else begin
                     ftw_d = swp_nxt[ACC_W-1:0];
                  end
               end
            end
            default: begin
            end
         endcase
         if (accept) begin
            ftw_d    = cfg_ftw;
            offset_d = cfg_phase;
            if (cfg_clr) begin
               acc_d  = '0;
               wrap_d = 1'b0;
            end
            if (cfg_sweep) begin
               step_d  = cfg_step;
               stop_d  = cfg_stop;
               state_d = ST_SWEEP;
            end else begin
               state_d = ST_RUN;
            end
         end
      end
   end

   // Address stage: one cycle behind the accumulator, frozen when disabled.
   always_comb begin
      phase_addr_d = phase_addr_q;
      if (enable || !active) begin
         phase_addr_d = acc_top + offset_q;
      end
      addr_valid_d = active && enable && !halt;
   end

   // Valid delay line matching the sine lookup latency; shifts every cycle.
   always_comb begin
      lut_d    = lut_q;
      lut_d[0] = addr_valid_q;
      for (int i = 1; i < LUT_LAT; i++) begin
         lut_d[i] = lut_q[i-1];
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         ftw_q    <= '0;
         step_q   <= '0;
         stop_q   <= '0;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         ftw_q    <= ftw_d;
         step_q   <= step_d;
         stop_q   <= stop_d;
         offset_q <= offset_d;
      end
   end

   // Output registers and lookup-valid pipeline.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_addr_q <= '0;
         addr_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
         sweep_done_q <= 1'b0;
         lut_q        <= '0;
      end else begin
         phase_addr_q <= phase_addr_d;
         addr_valid_q <= addr_valid_d;
         wrap_q       <= wrap_d;
         sweep_done_q <= sweep_done_d;
         lut_q        <= lut_d;
      end
   end

   assign phase_addr = phase_addr_q;
   assign addr_valid = addr_valid_q;
   assign lut_valid  = lut_q[LUT_LAT-1];
   assign wrap       = wrap_q;
   assign sweep_done = sweep_done_q;
   assign busy       = active;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Directed bench for dds_phase_accumulator (default build, no dither).
// Vector table for RUN/enable/halt behaviour, hand sequences for wrap and sweeps.
module tb_dds_phase_accumulator;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        halt;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        cfg_sweep;
   logic        cfg_clr;
   logic [31:0] cfg_ftw;
   logic [31:0] cfg_step;
   logic [31:0] cfg_stop;
   logic [10:0] cfg_phase;
   logic [10:0] phase_addr;
   logic        addr_valid;
   logic        lut_valid;
   logic        wrap;
   logic        sweep_done;
   logic        busy;

   int n_chk;
   int n_fail;

   dds_phase_accumulator #(
      .ACC_W   (32),
      .ADDR_W  (11),
      .LUT_LAT (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .halt       (halt),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_sweep  (cfg_sweep),
      .cfg_clr    (cfg_clr),
      .cfg_ftw    (cfg_ftw),
      .cfg_step   (cfg_step),
      .cfg_stop   (cfg_stop),
      .cfg_phase  (cfg_phase),
      .phase_addr (phase_addr),
      .addr_valid (addr_valid),
      .lut_valid  (lut_valid),
      .wrap       (wrap),
      .sweep_done (sweep_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        hlt;
      logic        vld;
      logic        clr;
      logic [31:0] ftw;
      logic [10:0] ph;
      logic [10:0] e_pa;
      logic        e_av;
      logic        e_lv;
      logic        e_busy;
      logic        e_rdy;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(
      input logic en, input logic hlt, input logic vld, input logic clr,
      input logic [31:0] ftw, input logic [10:0] ph,
      input logic [10:0] pa, input logic av, input logic lv,
      input logic bz, input logic rdy);
      vec_t v;
      v.en = en; v.hlt = hlt; v.vld = vld; v.clr = clr;
      v.ftw = ftw; v.ph = ph;
      v.e_pa = pa; v.e_av = av; v.e_lv = lv;
      v.e_busy = bz; v.e_rdy = rdy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic swp, input logic clr,
                      input logic [31:0] ftw, input logic [31:0] stp,
                      input logic [31:0] stop, input logic [10:0] ph);
      cfg_valid = 1'b1;
      cfg_sweep = swp;
      cfg_clr   = clr;
      cfg_ftw   = ftw;
      cfg_step  = stp;
      cfg_stop  = stop;
      cfg_phase = ph;
      step();
      cfg_valid = 1'b0;
      cfg_sweep = 1'b0;
      cfg_clr   = 1'b0;
   endtask

   logic [10:0] pa_prev;
   logic [10:0] ov_pa[6];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n = 1'b0; enable = 1'b0; halt = 1'b0;
      cfg_valid = 1'b0; cfg_sweep = 1'b0; cfg_clr = 1'b0;
      cfg_ftw = '0; cfg_step = '0; cfg_stop = '0; cfg_phase = '0;

      //  en hlt vld clr ftw           ph   | pa   av lv bz rdy
      tbl[0]  = mk(1,0,1,1,32'h0100_0000,11'd0,  11'd0,  0,0,1,1);
      tbl[1]  = mk(1,0,0,0,32'h0,        11'd0,  11'd0,  1,0,1,1);
      tbl[2]  = mk(1,0,0,0,32'h0,        11'd0,  11'd8,  1,0,1,1);
      tbl[3]  = mk(1,0,0,0,32'h0,        11'd0,  11'd16, 1,0,1,1);
      tbl[4]  = mk(1,0,0,0,32'h0,        11'd0,  11'd24, 1,1,1,1);
      tbl[5]  = mk(1,0,0,0,32'h0,        11'd0,  11'd32, 1,1,1,1);
      tbl[6]  = mk(1,0,1,0,32'h0200_0000,11'd100,11'd40, 1,1,1,1);
      tbl[7]  = mk(1,0,0,0,32'h0,        11'd0,  11'd148,1,1,1,1);
      tbl[8]  = mk(1,0,0,0,32'h0,        11'd0,  11'd164,1,1,1,1);
      tbl[9]  = mk(0,0,0,0,32'h0,        11'd0,  11'd164,0,1,1,1);
      tbl[10] = mk(0,0,0,0,32'h0,        11'd0,  11'd164,0,1,1,1);
      tbl[11] = mk(0,0,0,0,32'h0,        11'd0,  11'd164,0,1,1,1);
      tbl[12] = mk(0,0,0,0,32'h0,        11'd0,  11'd164,0,0,1,1);
      tbl[13] = mk(0,0,0,0,32'h0,        11'd0,  11'd164,0,0,1,1);
      tbl[14] = mk(1,0,0,0,32'h0,        11'd0,  11'd180,1,0,1,1);
      tbl[15] = mk(1,0,0,0,32'h0,        11'd0,  11'd196,1,0,1,1);
      tbl[16] = mk(1,1,1,0,32'h0700_0000,11'd7,  11'd212,0,0,0,0);
      tbl[17] = mk(1,0,0,0,32'h0,        11'd0,  11'd100,0,1,0,1);
      tbl[18] = mk(1,0,0,0,32'h0,        11'd0,  11'd100,0,1,0,1);
      tbl[19] = mk(1,0,0,0,32'h0,        11'd0,  11'd100,0,0,0,1);

      ov_pa[0] = 11'd0;   ov_pa[1] = 11'd0;   ov_pa[2] = 11'd24;
      ov_pa[3] = 11'd72;  ov_pa[4] = 11'd136; ov_pa[5] = 11'd200;

      // Reset
      step();
      step();
      rst_n = 1'b1;
      chk("rst_phase_addr", 32'(phase_addr), 32'd0);
      chk("rst_addr_valid", 32'(addr_valid), 32'd0);
      chk("rst_lut_valid",  32'(lut_valid),  32'd0);
      chk("rst_wrap",       32'(wrap),       32'd0);
      chk("rst_sweep_done", 32'(sweep_done), 32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_cfg_ready",  32'(cfg_ready),  32'd1);

      // Table: fixed FTW, FTW change with phase offset, enable gap, halt
      for (int i = 0; i < 20; i++) begin
         enable    = tbl[i].en;
         halt      = tbl[i].hlt;
         cfg_valid = tbl[i].vld;
         cfg_clr   = tbl[i].clr;
         cfg_sweep = 1'b0;
         cfg_ftw   = tbl[i].ftw;
         cfg_phase = tbl[i].ph;
         step();
         chk($sformatf("tbl%0d_pa", i),   32'(phase_addr), 32'(tbl[i].e_pa));
         chk($sformatf("tbl%0d_av", i),   32'(addr_valid), 32'(tbl[i].e_av));
         chk($sformatf("tbl%0d_lv", i),   32'(lut_valid),  32'(tbl[i].e_lv));
         chk($sformatf("tbl%0d_busy", i), 32'(busy),       32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_rdy", i),  32'(cfg_ready),  32'(tbl[i].e_rdy));
      end
      halt = 1'b0; cfg_valid = 1'b0; enable = 1'b1;

      // Wrap every 256 cycles at FTW = 2^24
      cfg(1'b0, 1'b1, 32'h0100_0000, 32'h0, 32'h0, 11'd0);
      for (int k = 1; k <= 520; k++) begin
         step();
         chk($sformatf("wrap_k%0d", k), 32'(wrap),
             32'((k == 256) || (k == 512)));
      end

      // Sweep: 16 enabled cycles to reach stop
      cfg(1'b1, 1'b1, 32'h0010_0000, 32'h0001_0000, 32'h0020_0000, 11'd0);
      chk("swp_ready_low", 32'(cfg_ready), 32'd0);
      chk("swp_busy",      32'(busy),      32'd1);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk($sformatf("swp_done_k%0d", k), 32'(sweep_done), 32'(k == 16));
         chk($sformatf("swp_rdy_k%0d", k),  32'(cfg_ready),  32'(k >= 16));
      end
      for (int k = 0; k < 4; k++) begin
         pa_prev = phase_addr;
         step();
         chk($sformatf("swp_hold_k%0d", k), 32'(phase_addr),
             32'(11'(pa_prev + 11'd1)));
      end

      // Overshoot: FTW 0, 3, 6, then clamp to 8 (x2^24)
      cfg(1'b1, 1'b1, 32'h0, 32'h0300_0000, 32'h0800_0000, 11'd0);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk($sformatf("ovs_done_k%0d", k), 32'(sweep_done), 32'(k == 3));
         chk($sformatf("ovs_pa_k%0d", k),   32'(phase_addr), 32'(ov_pa[k-1]));
      end

      // Reset mid-sweep abandons it, flushes lut_valid
      cfg(1'b1, 1'b1, 32'h0010_0000, 32'h0001_0000, 32'h0020_0000, 11'd5);
      for (int k = 0; k < 5; k++) step();
      chk("pre_rst_lv", 32'(lut_valid), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_busy", 32'(busy),       32'd0);
      chk("mid_rst_done", 32'(sweep_done), 32'd0);
      chk("mid_rst_pa",   32'(phase_addr), 32'd0);
      chk("mid_rst_av",   32'(addr_valid), 32'd0);
      chk("mid_rst_lv",   32'(lut_valid),  32'd0);
      chk("mid_rst_rdy",  32'(cfg_ready),  32'd1);
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("post_rst_done_k%0d", k), 32'(sweep_done), 32'd0);
         chk($sformatf("post_rst_busy_k%0d", k), 32'(busy),       32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
